// File: rtl/tcm_port_arbiter_if.sv
// rtl/tcm_port_arbiter_if.sv - fetch/stbuf request ports and single-port TCM bus
interface tcm_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int SIZE_W = 3
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [DATA_W-1:0] fetch_rdata;

    logic              st_rd_req;
    logic [ADDR_W-1:0] st_rd_addr;
    logic [SIZE_W-1:0] st_rd_size;
    logic              st_rd_ack;
    logic [DATA_W-1:0] st_rdata;

    logic              st_wr_req;
    logic [ADDR_W-1:0] st_wr_addr;
    logic [SIZE_W-1:0] st_wr_size;
    logic [DATA_W-1:0] st_wr_data;
    logic              st_wr_ack;

    logic [ADDR_W-1:0] tcm_addr;
    logic [SIZE_W-1:0] tcm_size;
    logic [DATA_W-1:0] tcm_wdata;
    logic              tcm_rd;
    logic              tcm_wr;
    logic [DATA_W-1:0] tcm_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        input  st_rd_req, st_rd_addr, st_rd_size,
        input  st_wr_req, st_wr_addr, st_wr_size, st_wr_data,
        input  tcm_rdata,
        output fetch_ack, fetch_rdata, st_rd_ack, st_rdata, st_wr_ack,
        output tcm_addr, tcm_size, tcm_wdata, tcm_rd, tcm_wr
    );

    modport master (
        output fetch_req, fetch_addr,
        output st_rd_req, st_rd_addr, st_rd_size,
        output st_wr_req, st_wr_addr, st_wr_size, st_wr_data,
        output tcm_rdata,
        input  fetch_ack, fetch_rdata, st_rd_ack, st_rdata, st_wr_ack,
        input  tcm_addr, tcm_size, tcm_wdata, tcm_rd, tcm_wr
    );
endinterface

// File: rtl/tcm_port_arbiter.sv
// rtl/tcm_port_arbiter.sv - one-access-per-cycle TCM arbiter for fetch, stbuf read, stbuf write
// Optional conflict counter enabled by defining TCM_ARB_PERF_EN.
module tcm_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int SIZE_W     = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef TCM_ARB_PERF_EN
    input  logic                 perf_clr,
    output logic [31:0]          conflict_cnt,
`endif
    tcm_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        G_NONE  = 2'd0,
        G_FETCH = 2'd1,
        G_ST_RD = 2'd2,
        G_ST_WR = 2'd3
    } grant_t;

    localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [SIZE_W-1:0] FETCH_SIZE = SIZE_W'(3);

    grant_t     last_grant;
    grant_t     grant;
    logic [3:0] starve_cnt;
    logic       fetch_elig;
    logic       rd_elig;
    logic       wr_elig;

    // Acks come straight from the grant register, so reset clears them at once.
    assign bus.fetch_ack = (last_grant == G_FETCH);
    assign bus.st_rd_ack = (last_grant == G_ST_RD);
    assign bus.st_wr_ack = (last_grant == G_ST_WR);

    assign bus.fetch_rdata = rst ? {DATA_W{1'b0}} : bus.tcm_rdata;
    assign bus.st_rdata    = rst ? {DATA_W{1'b0}} : bus.tcm_rdata;

    // A requester in its ack cycle still holds req; masking it avoids a duplicate issue.
    assign fetch_elig = bus.fetch_req & ~bus.fetch_ack & ~rst;
    assign rd_elig    = bus.st_rd_req & ~bus.st_rd_ack & ~rst;
    assign wr_elig    = bus.st_wr_req & ~bus.st_wr_ack & ~rst;

    always_comb begin
        grant = G_NONE;
        if (fetch_elig && starve_cnt == STARVE_LIM) grant = G_FETCH;
        else if (wr_elig)                          grant = G_ST_WR;
        else if (rd_elig)                          grant = G_ST_RD;
        else if (fetch_elig)                       grant = G_FETCH;
    end

    always_comb begin
        bus.tcm_addr  = {ADDR_W{1'b0}};
        bus.tcm_size  = {SIZE_W{1'b0}};
        bus.tcm_wdata = {DATA_W{1'b0}};
        bus.tcm_rd    = 1'b0;
        bus.tcm_wr    = 1'b0;
        case (grant)
            G_FETCH: begin
                bus.tcm_addr = bus.fetch_addr;
                bus.tcm_size = FETCH_SIZE;
                bus.tcm_rd   = 1'b1;
            end
            G_ST_RD: begin
                bus.tcm_addr = bus.st_rd_addr;
                bus.tcm_size = bus.st_rd_size;
                bus.tcm_rd   = 1'b1;
            end
            G_ST_WR: begin
                bus.tcm_addr  = bus.st_wr_addr;
                bus.tcm_size  = bus.st_wr_size;
                bus.tcm_wdata = bus.st_wr_data;
                bus.tcm_wr    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= G_NONE;
            starve_cnt <= 4'd0;
        end else begin
            last_grant <= grant;
            if (!bus.fetch_req || grant == G_FETCH)
                starve_cnt <= 4'd0;
            else if (fetch_elig && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef TCM_ARB_PERF_EN
    logic [1:0] elig_num;
    assign elig_num = {1'b0, fetch_elig} + {1'b0, rd_elig} + {1'b0, wr_elig};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_cnt <= 32'd0;
        else if (perf_clr)
            conflict_cnt <= 32'd0;
        else if (elig_num >= 2'd2)
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_tcm_port_arbiter.sv
// tb/tb_tcm_port_arbiter.sv - randomized self-checking bench for tcm_port_arbiter
module tb_tcm_port_arbiter;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tcm_port_arbiter_if #(.ADDR_W(32), .DATA_W(64), .SIZE_W(3)) bus ();

`ifdef TCM_ARB_PERF_EN
    logic        perf_clr;
    logic [31:0] conflict_cnt;
`endif

    tcm_port_arbiter #(.ADDR_W(32), .DATA_W(64), .SIZE_W(3), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk),
        .rst(rst),
`ifdef TCM_ARB_PERF_EN
        .perf_clr(perf_clr),
        .conflict_cnt(conflict_cnt),
`endif
        .bus(bus)
    );

    // TCM behaviour: one registered read port, write takes effect at the edge.
    logic [63:0] tmem [16];
    always @(posedge clk) begin
        if (bus.tcm_wr) tmem[bus.tcm_addr[6:3]] <= bus.tcm_wdata;
        if (bus.tcm_rd) bus.tcm_rdata <= tmem[bus.tcm_addr[6:3]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Requester index: 0 = fetch, 1 = stbuf read, 2 = stbuf write.
    bit          req   [3];
    logic [31:0] raddr [3];
    logic [2:0]  rsize [3];
    logic [63:0] wdata;
    bit          done  [3];
    bit          stage [3];
    logic [31:0] saddr [3];
    logic [2:0]  ssize [3];
    logic [63:0] sdata;
    int          rate  [3];
    bit          pclr, pclr_stage;

    // Reference model state.
    logic [63:0] refm [16];
    bit   [2:0]  m_ack;
    int          m_starve;
    logic [63:0] m_rexp;
    logic [31:0] m_conf;

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 15)) << 3;
    endfunction

    task automatic drive_bus();
        bus.fetch_req  = req[0];
        bus.fetch_addr = raddr[0];
        bus.st_rd_req  = req[1];
        bus.st_rd_addr = raddr[1];
        bus.st_rd_size = rsize[1];
        bus.st_wr_req  = req[2];
        bus.st_wr_addr = raddr[2];
        bus.st_wr_size = rsize[2];
        bus.st_wr_data = wdata;
`ifdef TCM_ARB_PERF_EN
        perf_clr = pclr;
`endif
    endtask

    task automatic model_reset();
        m_ack = 3'b000; m_starve = 0; m_rexp = '0; m_conf = '0;
        pclr = 0; pclr_stage = 0; wdata = '0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 0; done[i] = 0; stage[i] = 0; rate[i] = 0;
            raddr[i] = '0; rsize[i] = '0;
        end
    endtask

    task automatic cycle();
        logic [2:0] ack_dut;
        bit   elig [3];
        int   g, ne;
        logic exp_rd, exp_wr;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            if (done[i]) begin done[i] = 0; req[i] = 0; end
            if (!req[i]) begin
                if (stage[i]) begin
                    req[i] = 1; raddr[i] = saddr[i]; rsize[i] = ssize[i];
                    if (i == 2) wdata = sdata;
                    stage[i] = 0;
                end else if (rate[i] > 0 && $urandom_range(1, 100) <= rate[i]) begin
                    req[i] = 1; raddr[i] = rnd_addr(); rsize[i] = 3'($urandom_range(0, 7));
                    if (i == 2) wdata = {$urandom, $urandom};
                end
            end
        end
        pclr = pclr_stage; pclr_stage = 0;
        drive_bus();
        @(negedge clk);
        ack_dut = {bus.st_wr_ack, bus.st_rd_ack, bus.fetch_ack};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ack_dut[i] !== m_ack[i]) begin
                n_fail++; $display("FAIL ack[%0d] got %b want %b", i, ack_dut[i], m_ack[i]);
            end
        end
        if (m_ack[0]) begin
            n_checks++;
            if (bus.fetch_rdata !== m_rexp) begin
                n_fail++; $display("FAIL fetch_rdata got %h want %h", bus.fetch_rdata, m_rexp);
            end
        end
        if (m_ack[1]) begin
            n_checks++;
            if (bus.st_rdata !== m_rexp) begin
                n_fail++; $display("FAIL st_rdata got %h want %h", bus.st_rdata, m_rexp);
            end
        end
`ifdef TCM_ARB_PERF_EN
        n_checks++;
        if (conflict_cnt !== m_conf) begin
            n_fail++; $display("FAIL conflict_cnt got %0d want %0d", conflict_cnt, m_conf);
        end
`endif
        ne = 0;
        for (int i = 0; i < 3; i++) begin
            elig[i] = req[i] && !m_ack[i];
            if (elig[i]) ne++;
        end
        g = -1;
        if (elig[0] && m_starve == STARVE_MAX) g = 0;
        else if (elig[2]) g = 2;
        else if (elig[1]) g = 1;
        else if (elig[0]) g = 0;
        exp_rd = (g == 0 || g == 1);
        exp_wr = (g == 2);
        n_checks++;
        if (bus.tcm_rd !== exp_rd || bus.tcm_wr !== exp_wr) begin
            n_fail++;
            $display("FAIL strobes got rd=%b wr=%b want rd=%b wr=%b", bus.tcm_rd, bus.tcm_wr, exp_rd, exp_wr);
        end
        if (g >= 0) begin
            n_checks++;
            if (bus.tcm_addr !== raddr[g] || bus.tcm_size !== ((g == 0) ? 3'b011 : rsize[g])) begin
                n_fail++;
                $display("FAIL tcm_addr/size got %h/%0d want %h/%0d", bus.tcm_addr, bus.tcm_size,
                         raddr[g], (g == 0) ? 3'b011 : rsize[g]);
            end
        end
        if (g == 2) begin
            n_checks++;
            if (bus.tcm_wdata !== wdata) begin
                n_fail++; $display("FAIL tcm_wdata got %h want %h", bus.tcm_wdata, wdata);
            end
        end
        for (int i = 0; i < 3; i++) if (m_ack[i]) done[i] = 1;
        if (pclr) m_conf = '0;
        else if (ne >= 2) m_conf = m_conf + 32'd1;
        if (!req[0] || g == 0) m_starve = 0;
        else if (elig[0] && m_starve < STARVE_MAX) m_starve++;
        if (g == 2) refm[raddr[2][6:3]] = wdata;
        else if (g >= 0) m_rexp = refm[raddr[g][6:3]];
        m_ack = 3'b000;
        if (g >= 0) m_ack[g] = 1'b1;
    endtask

    task automatic do_stage(input int i, input logic [31:0] a, input logic [2:0] s, input logic [63:0] d);
        stage[i] = 1; saddr[i] = a; ssize[i] = s;
        if (i == 2) sdata = d;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) rate[i] = 0;
        for (int k = 0; k < 6; k++) cycle();
    endtask

    task automatic test_reset();
        model_reset();
        drive_bus();
        @(negedge clk);
        n_checks++;
        if ({bus.fetch_ack, bus.st_rd_ack, bus.st_wr_ack, bus.tcm_rd, bus.tcm_wr} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b want 00000",
                     {bus.fetch_ack, bus.st_rd_ack, bus.st_wr_ack, bus.tcm_rd, bus.tcm_wr});
        end
`ifdef TCM_ARB_PERF_EN
        n_checks++;
        if (conflict_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_conflict got %0d want 0", conflict_cnt);
        end
`endif
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        tmem[8] = 64'h0000_0000_DEAD_BEEF;
        refm[8] = 64'h0000_0000_DEAD_BEEF;
        do_stage(0, 32'h40, 3'd0, '0);
        cycle();
        n_checks++;
        if (bus.tcm_rd !== 1'b1 || bus.tcm_addr !== 32'h40) begin
            n_fail++; $display("FAIL single_fetch_issue got rd=%b addr=%h want rd=1 addr=40", bus.tcm_rd, bus.tcm_addr);
        end
        cycle();
        n_checks++;
        if (bus.fetch_ack !== 1'b1 || bus.fetch_rdata !== 64'hDEADBEEF || bus.st_rd_ack !== 1'b0 || bus.st_wr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL single_fetch_ack got ack=%b rdata=%h others=%b%b want ack=1 rdata=deadbeef others=00",
                     bus.fetch_ack, bus.fetch_rdata, bus.st_rd_ack, bus.st_wr_ack);
        end
        drain();
    endtask

    task automatic test_all_three();
        do_stage(0, 32'h10, 3'd0, '0);
        do_stage(1, 32'h20, 3'd2, '0);
        do_stage(2, 32'h30, 3'd3, 64'h1122_3344_5566_7788);
        cycle();
        n_checks++;
        if (bus.tcm_wr !== 1'b1 || bus.tcm_addr !== 32'h30) begin
            n_fail++; $display("FAIL all3_c0 got wr=%b addr=%h want wr=1 addr=30", bus.tcm_wr, bus.tcm_addr);
        end
        cycle();
        n_checks++;
        if (bus.st_wr_ack !== 1'b1 || bus.tcm_rd !== 1'b1 || bus.tcm_addr !== 32'h20) begin
            n_fail++; $display("FAIL all3_c1 got wack=%b rd=%b addr=%h want 1 1 20", bus.st_wr_ack, bus.tcm_rd, bus.tcm_addr);
        end
        cycle();
        n_checks++;
        if (bus.st_rd_ack !== 1'b1 || bus.tcm_rd !== 1'b1 || bus.tcm_addr !== 32'h10) begin
            n_fail++; $display("FAIL all3_c2 got rack=%b rd=%b addr=%h want 1 1 10", bus.st_rd_ack, bus.tcm_rd, bus.tcm_addr);
        end
        cycle();
        n_checks++;
        if (bus.fetch_ack !== 1'b1) begin
            n_fail++; $display("FAIL all3_c3 got fetch_ack=%b want 1", bus.fetch_ack);
        end
        drain();
    endtask

    task automatic test_ack_mask();
        int n_wack = 0;
        do_stage(2, 32'h58, 3'd1, 64'hA5A5_0000_FFFF_1234);
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (bus.st_wr_ack === 1'b1) begin
                n_wack++;
                n_checks++;
                if (bus.tcm_wr !== 1'b0 || bus.st_wr_req !== 1'b1) begin
                    n_fail++; $display("FAIL ack_mask_rewrite got tcm_wr=%b req=%b want 0 1", bus.tcm_wr, bus.st_wr_req);
                end
            end
        end
        n_checks++;
        if (n_wack != 1) begin
            n_fail++; $display("FAIL ack_mask_pulses got %0d want 1", n_wack);
        end
    endtask

    task automatic test_starvation();
        int found = -1;
        rate[1] = 100; rate[2] = 100;
        do_stage(0, 32'h78, 3'd0, '0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (found < 0 && bus.fetch_ack === 1'b1) found = k;
        end
        n_checks++;
        if (found < 1 || found > STARVE_MAX + 1) begin
            n_fail++; $display("FAIL starve_grant got ack_cycle=%0d want 1..%0d", found, STARVE_MAX + 1);
        end
        drain();
        n_checks++;
        if (dut.starve_cnt !== 4'd0) begin
            n_fail++; $display("FAIL starve_clear got %0d want 0", dut.starve_cnt);
        end
    endtask

    task automatic test_perf();
`ifdef TCM_ARB_PERF_EN
        pclr_stage = 1;
        cycle();
        for (int i = 0; i < 3; i++) rate[i] = 100;
        for (int k = 0; k < 10; k++) cycle();
        for (int i = 0; i < 3; i++) rate[i] = 0;
        cycle();
        n_checks++;
        if (conflict_cnt !== 32'd10) begin
            n_fail++; $display("FAIL perf_count got %0d want 10", conflict_cnt);
        end
        pclr_stage = 1;
        cycle();
        cycle();
        n_checks++;
        if (conflict_cnt !== 32'd0 && m_conf == 32'd0) begin
            n_fail++; $display("FAIL perf_clr got %0d want 0", conflict_cnt);
        end
        drain();
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) rate[i] = 50;
        for (int k = 0; k < 400; k++) cycle();
        drain();
    endtask

    task automatic test_async_reset();
        do_stage(0, 32'h48, 3'd0, '0);
        do_stage(2, 32'h50, 3'd2, 64'hCAFE_F00D_0BAD_BEEF);
        rate[2] = 100;
        cycle();
        cycle();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.fetch_ack, bus.st_rd_ack, bus.st_wr_ack, bus.tcm_rd, bus.tcm_wr} !== 5'b0) begin
            n_fail++;
            $display("FAIL async_reset got %b want 00000",
                     {bus.fetch_ack, bus.st_rd_ack, bus.st_wr_ack, bus.tcm_rd, bus.tcm_wr});
        end
        model_reset();
        drive_bus();
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if ({bus.fetch_ack, bus.st_rd_ack, bus.st_wr_ack, bus.tcm_rd, bus.tcm_wr} !== 5'b0) begin
                n_fail++;
                $display("FAIL post_reset_idle got %b want 00000",
                         {bus.fetch_ack, bus.st_rd_ack, bus.st_wr_ack, bus.tcm_rd, bus.tcm_wr});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tmem[i] = {$urandom, $urandom};
            refm[i] = tmem[i];
        end
        test_reset();
        test_single_fetch();
        test_all_three();
        test_ack_mask();
        test_starvation();
        test_perf();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
